// File: rtl/elk_shift_pkg.sv
// elk_shift_pkg: shared types, register map and rotator control helpers
// for the shared shift arbiter.
package elk_shift_pkg;

  // Shift operation encoding as presented on req_op.
  typedef enum logic [1:0] {
    ROR = 2'b00,
    ROL = 2'b01,
    SRL = 2'b10,
    SLL = 2'b11
  } shop_t;

  // Arbiter sequencing states.
  typedef enum logic [1:0] {
    ARB  = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_t;

  // Slot register map, decoded on addr[1:0].
  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_OPCNT  = 2'd2;
  localparam logic [1:0] ADDR_RSVD   = 2'd3;

  // Rotate-right amount for the shared rotator; left ops use (32-amt) mod 32.
  function automatic logic [4:0] rot_sel(input shop_t op, input logic [4:0] amt);
    logic [4:0] sel;
    case (op)
      ROL, SLL: sel = 5'd0 - amt;
      default:  sel = amt;
    endcase
    return sel;
  endfunction

  // Mask that turns a rotate into a logical shift by clearing wrapped bits.
  function automatic logic [31:0] keep_mask(input shop_t op, input logic [4:0] amt);
    logic [31:0] m;
    case (op)
      SRL:     m = 32'hFFFF_FFFF >> amt;
      SLL:     m = 32'hFFFF_FFFF << amt;
      default: m = 32'hFFFF_FFFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/elk_shift_arb_barrel32.sv
// barrel32: 32-bit rotate-right by Sel, built as five log2 stages.
module barrel32 (
  input  logic [31:0] Data_IN,
  input  logic [4:0]  Sel,
  output logic [31:0] Data_OUT
);

  logic [31:0] s0_s;
  logic [31:0] s1_s;
  logic [31:0] s2_s;
  logic [31:0] s3_s;

  // Each stage rotates right by a power of two when its Sel bit is set.
  always_comb begin
    s0_s     = Sel[0] ? {Data_IN[0],    Data_IN[31:1]} : Data_IN;
    s1_s     = Sel[1] ? {s0_s[1:0],     s0_s[31:2]}    : s0_s;
    s2_s     = Sel[2] ? {s1_s[3:0],     s1_s[31:4]}    : s1_s;
    s3_s     = Sel[3] ? {s2_s[7:0],     s2_s[31:8]}    : s2_s;
    Data_OUT = Sel[4] ? {s3_s[15:0],    s3_s[31:16]}   : s3_s;
  end

endmodule

// File: rtl/elk_shift_arb.sv
// elk_shift_arb: round-robin sharing of one barrel rotator among NREQ
// requesters, one op in flight (ARB -> EXEC -> RESP), with a small slot
// register block for enable/mask control, status and a completed-op count.
module elk_shift_arb
  import elk_shift_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cs,
  input  logic                 read,
  input  logic                 write,
  input  logic [4:0]           addr,
  input  logic [31:0]          wr_data,
  output logic [31:0]          rd_data,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*32-1:0]   req_data,
  input  logic [NREQ*5-1:0]    req_amt,
  input  logic [NREQ*2-1:0]    req_op,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [31:0]          rsp_data
);

  localparam int IW = $clog2(NREQ);

  state_t            state_q;
  logic [IW-1:0]     rr_ptr_q;
  logic [IW-1:0]     idx_q;
  logic [IW-1:0]     last_idx_q;
  logic [31:0]       data_q;
  logic [4:0]        amt_q;
  shop_t             op_q;
  logic [NREQ-1:0]   rsp_valid_q;
  logic [31:0]       rsp_data_q;
  logic              en_q;
  logic [NREQ-1:0]   mask_q;
  logic [31:0]       opcnt_q;
  logic [31:0]       opcnt_d;
  logic [31:0]       rd_data_q;

  logic [NREQ-1:0]   elig_s;
  logic              win_found_s;
  logic [IW-1:0]     win_idx_s;
  logic [IW-1:0]     rr_next_s;
  logic [NREQ-1:0]   idx_onehot_s;
  logic [4:0]        sel_s;
  logic [31:0]       rot_s;
  logic [31:0]       result_s;
  logic              rsp_done_s;
  logic              wr_opcnt_s;
  logic [31:0]       status_s;
  logic [31:0]       ctrl_s;
  logic              unused_s;

  // Upper address bits and unmapped write-data bits carry no meaning.
  assign unused_s = ^{addr[4:2], wr_data};

  // Round-robin pick: first eligible requester at or above rr_ptr, wrapping.
  always_comb begin : pick
    int unsigned j;
    if (en_q) begin
      elig_s = req_valid & mask_q;
    end else begin
      elig_s = '0;
    end
    win_found_s = 1'b0;
    win_idx_s   = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(rr_ptr_q) + k;
      if (j >= NREQ) begin
        j = j - NREQ;
      end else begin
        j = j;
      end
      if (!win_found_s && elig_s[j]) begin
        win_found_s = 1'b1;
        win_idx_s   = IW'(j);
      end else begin
        win_idx_s   = win_idx_s;
      end
    end
    if (win_idx_s == IW'(NREQ - 1)) begin
      rr_next_s = '0;
    end else begin
      rr_next_s = win_idx_s + IW'(1);
    end
  end

  // Grant is combinational and only offered in ARB outside reset.
  always_comb begin
    req_ready = '0;
    if (!reset && (state_q == ARB) && win_found_s) begin
      req_ready[win_idx_s] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  // One-hot of the op owner, used when raising the response.
  always_comb begin
    idx_onehot_s        = '0;
    idx_onehot_s[idx_q] = 1'b1;
  end

  // Rotator control and logical-shift masking of the rotated operand.
  always_comb begin
    sel_s    = rot_sel(op_q, amt_q);
    result_s = rot_s & keep_mask(op_q, amt_q);
  end

  barrel32 u_rot (
    .Data_IN  (data_q),
    .Sel      (sel_s),
    .Data_OUT (rot_s)
  );

  // Completion handshake and op-counter next value; a register write wins over an increment.
  always_comb begin
    rsp_done_s = (state_q == RESP) && rsp_ready[idx_q];
    wr_opcnt_s = cs && write && (addr[1:0] == ADDR_OPCNT);
    if (wr_opcnt_s) begin
      opcnt_d = 32'd0;
    end else if (rsp_done_s) begin
      opcnt_d = opcnt_q + 32'd1;
    end else begin
      opcnt_d = opcnt_q;
    end
  end

  // Read views of CTRL and STATUS.
  always_comb begin
    ctrl_s               = '0;
    ctrl_s[0]            = en_q;
    ctrl_s[8 +: NREQ]    = mask_q;
    status_s             = '0;
    status_s[0]          = (state_q != ARB);
    status_s[4 +: IW]    = last_idx_q;
    status_s[8 +: NREQ]  = req_valid;
  end

  // Op sequencer: arbitrate, execute on the rotator, hold the response until accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ARB;
      rr_ptr_q    <= '0;
      idx_q       <= '0;
      last_idx_q  <= '0;
      data_q      <= 32'd0;
      amt_q       <= 5'd0;
      op_q        <= ROR;
      rsp_valid_q <= '0;
      rsp_data_q  <= 32'd0;
    end else begin
      case (state_q)
        ARB: begin
          if (win_found_s) begin
            idx_q      <= win_idx_s;
            last_idx_q <= win_idx_s;
            data_q     <= req_data[32*win_idx_s +: 32];
            amt_q      <= req_amt[5*win_idx_s +: 5];
            op_q       <= shop_t'(req_op[2*win_idx_s +: 2]);
            rr_ptr_q   <= rr_next_s;
            state_q    <= EXEC;
          end else begin
            state_q    <= ARB;
          end
        end
        EXEC: begin
          rsp_data_q  <= result_s;
          rsp_valid_q <= idx_onehot_s;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_done_s) begin
            rsp_valid_q <= '0;
            state_q     <= ARB;
          end else begin
            state_q     <= RESP;
          end
        end
        default: begin
          rsp_valid_q <= '0;
          state_q     <= ARB;
        end
      endcase
    end
  end

  // Slot register writes and the completed-op counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_q    <= 1'b1;
      mask_q  <= '1;
      opcnt_q <= 32'd0;
    end else begin
      opcnt_q <= opcnt_d;
      if (cs && write) begin
        case (addr[1:0])
          ADDR_CTRL: begin
            en_q   <= wr_data[0];
            mask_q <= wr_data[8 +: NREQ];
          end
          default: begin
            en_q   <= en_q;
            mask_q <= mask_q;
          end
        endcase
      end else begin
        en_q   <= en_q;
        mask_q <= mask_q;
      end
    end
  end

  // Registered read port; captures pre-write contents on a simultaneous write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_q <= 32'd0;
    end else if (cs && read) begin
      case (addr[1:0])
        ADDR_CTRL:   rd_data_q <= ctrl_s;
        ADDR_STATUS: rd_data_q <= status_s;
        ADDR_OPCNT:  rd_data_q <= opcnt_q;
        default:     rd_data_q <= 32'd0;
      endcase
    end else begin
      rd_data_q <= rd_data_q;
    end
  end

  assign rd_data   = rd_data_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_elk_shift_arb.sv
// tb_elk_shift_arb: scoreboard bench for the shared shift arbiter.
module tb_elk_shift_arb;

  localparam int NREQ = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cs = 1'b0;
  logic              read = 1'b0;
  logic              write = 1'b0;
  logic [4:0]        addr = 5'd0;
  logic [31:0]       wr_data = 32'd0;
  logic [31:0]       rd_data;
  logic [NREQ-1:0]   req_valid = 4'hF;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*32-1:0] req_data = '0;
  logic [NREQ*5-1:0] req_amt = '0;
  logic [NREQ*2-1:0] req_op = '0;
  logic [NREQ-1:0]   rsp_valid;
  logic [NREQ-1:0]   rsp_ready = 4'hF;
  logic [31:0]       rsp_data;

  elk_shift_arb #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .reset     (reset),
    .cs        (cs),
    .read      (read),
    .write     (write),
    .addr      (addr),
    .wr_data   (wr_data),
    .rd_data   (rd_data),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_amt   (req_amt),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference shifter: one bit position per step.
  function automatic logic [31:0] model(input logic [31:0] d, input logic [4:0] a, input logic [1:0] op);
    logic [31:0] r;
    r = d;
    for (int k = 0; k < int'(a); k++) begin
      case (op)
        2'b00:   r = {r[0], r[31:1]};
        2'b01:   r = {r[30:0], r[31]};
        2'b10:   r = {1'b0, r[31:1]};
        default: r = {r[30:0], 1'b0};
      endcase
    end
    return r;
  endfunction

  typedef struct {
    int          idx;
    logic [31:0] data;
  } exp_t;
  exp_t sb_q[$];

  task automatic push_exp(input int i, input logic [31:0] d);
    exp_t e;
    e.idx  = i;
    e.data = d;
    sb_q.push_back(e);
  endtask

  // Response monitor: every accepted response is popped and compared.
  always @(negedge clk) begin
    #1;
    if (!reset && ((rsp_valid & rsp_ready) != 4'd0)) begin
      if (sb_q.size() == 0) begin
        chk("sb_extra", {28'd0, rsp_valid}, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("rsp_idx", {28'd0, rsp_valid}, 32'd1 << e.idx);
        chk("rsp_data", rsp_data, e.data);
      end
    end
  end

  task automatic set_req(input int i, input logic [31:0] d, input logic [4:0] a, input logic [1:0] op);
    req_data[32*i +: 32] = d;
    req_amt[5*i +: 5]    = a;
    req_op[2*i +: 2]     = op;
  endtask

  task automatic wait_any_grant(output logic [3:0] g, output int gc);
    for (int n = 0; n < 30; n++) begin
      #1;
      if (req_ready != 4'd0) begin
        g  = req_ready;
        gc = cyc;
        return;
      end
      @(negedge clk);
    end
    g  = 4'd0;
    gc = cyc;
    chk("grant_timeout", 32'd0, 32'd1);
  endtask

  task automatic issue(input int i, input logic [31:0] d, input logic [4:0] a, input logic [1:0] op,
                       input logic [31:0] exp, input bit push, output int gc);
    logic [3:0] g;
    @(negedge clk);
    set_req(i, d, a, op);
    req_valid[i] = 1'b1;
    if (push) push_exp(i, exp);
    wait_any_grant(g, gc);
    chk("grant_idx", {28'd0, g}, 32'd1 << i);
    @(negedge clk);
    req_valid[i] = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 60; n++) begin
      if (sb_q.size() == 0) break;
      @(negedge clk);
      #2;
    end
    chk("drain", sb_q.size(), 32'd0);
  endtask

  task automatic reg_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
    @(negedge clk);
    cs = 1'b0; write = 1'b0;
  endtask

  task automatic reg_read(input logic [4:0] a, output logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; read = 1'b1; addr = a;
    @(negedge clk);
    cs = 1'b0; read = 1'b0;
    #1;
    d = rd_data;
  endtask

  task automatic reg_rw(input logic [4:0] a, input logic [31:0] wd, output logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; read = 1'b1; write = 1'b1; addr = a; wr_data = wd;
    @(negedge clk);
    cs = 1'b0; read = 1'b0; write = 1'b0;
    #1;
    d = rd_data;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0]  gv;
    logic [3:0]  acc;
    logic [31:0] rd;
    logic [31:0] ed;
    int          gc;
    int          prev;
    bit          ok;

    // Reset state, with all requesters valid to show no grant leaks out.
    @(negedge clk);
    #1;
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_rsp_valid", {28'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_req_ready", {28'd0, req_ready}, 32'd0);
    req_valid = 4'd0;
    @(negedge clk);
    reset = 1'b0;
    reg_read(5'd1, rd);  chk("rst_status", rd, 32'd0);
    reg_read(5'd0, rd);  chk("rst_ctrl", rd, 32'h0000_0F01);
    reg_read(5'd2, rd);  chk("rst_opcnt", rd, 32'd0);

    // Single ROR op with grant-to-response latency.
    issue(0, 32'h8000_0001, 5'd4, 2'b00, 32'h1800_0000, 1'b1, gc);
    #1;
    chk("lat_t1", {28'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    #1;
    chk("lat_t2", {28'd0, rsp_valid}, 32'd1);
    chk("lat_cyc", cyc - gc, 32'd2);
    chk("t1_data", rsp_data, 32'h1800_0000);
    drain();

    // Each op type, then amount 0 on every op.
    issue(1, 32'hF000_000F, 5'd4, 2'b01, 32'h0000_00FF, 1'b1, gc);
    issue(2, 32'hF000_000F, 5'd4, 2'b10, 32'h0F00_0000, 1'b1, gc);
    issue(3, 32'hF000_000F, 5'd4, 2'b11, 32'h0000_00F0, 1'b1, gc);
    for (int i = 0; i < 4; i++) begin
      issue(i, 32'hC3A5_5A3C, 5'd0, 2'(i), 32'hC3A5_5A3C, 1'b1, gc);
    end
    drain();
    reg_write(5'd2, 32'h1234_5678);

    // All requesters valid: round-robin order and issue interval.
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      set_req(i, 32'h1111_1111 * (i + 1), 5'(i + 1), 2'(i));
    end
    req_valid = 4'hF;
    for (int g = 0; g < 5; g++) begin
      push_exp(g % 4, model(32'h1111_1111 * ((g % 4) + 1), 5'((g % 4) + 1), 2'(g % 4)));
    end
    prev = 0;
    for (int g = 0; g < 5; g++) begin
      wait_any_grant(gv, gc);
      chk("rr_grant", {28'd0, gv}, 32'd1 << (g % 4));
      if (g > 0) chk("rr_gap", gc - prev, 32'd3);
      prev = gc;
      @(negedge clk);
    end
    req_valid = 4'd0;
    drain();
    reg_rw(5'd2, 32'hFFFF_FFFF, rd);  chk("opcnt_rw_old", rd, 32'd5);
    reg_read(5'd2, rd);               chk("opcnt_cleared", rd, 32'd0);

    // Reserved address and upper-address aliasing.
    reg_write(5'd3, 32'hFFFF_FFFF);
    reg_read(5'd3, rd);   chk("rsvd_read", rd, 32'd0);

    // Masking: req1 masked off, only req2 may win.
    reg_write(5'd0, 32'h0000_0D01);
    reg_read(5'd20, rd);  chk("ctrl_alias", rd, 32'h0000_0D01);
    @(negedge clk);
    set_req(1, 32'h0000_FFFF, 5'd8, 2'b01);
    set_req(2, 32'h0000_FFFF, 5'd8, 2'b00);
    req_valid = 4'b0110;
    push_exp(2, model(32'h0000_FFFF, 5'd8, 2'b00));
    wait_any_grant(gv, gc);
    chk("mask_grant", {28'd0, gv}, 32'h4);
    @(negedge clk);
    req_valid = 4'b0010;
    acc = 4'd0;
    repeat (8) begin
      #1;
      acc = acc | req_ready;
      @(negedge clk);
    end
    chk("mask_block", {28'd0, acc}, 32'd0);
    req_valid = 4'd0;
    drain();
    reg_write(5'd0, 32'd0);
    @(negedge clk);
    req_valid = 4'hF;
    acc = 4'd0;
    repeat (6) begin
      #1;
      acc = acc | req_ready;
      @(negedge clk);
    end
    chk("en_block", {28'd0, acc}, 32'd0);
    reg_read(5'd1, rd);  chk("en_status", rd, 32'h0000_0F20);
    req_valid = 4'd0;
    reg_write(5'd0, 32'h0000_0F01);

    // Response backpressure on req2.
    reg_write(5'd2, 32'd0);
    rsp_ready = 4'b1011;
    ed = model(32'hDEAD_BEEF, 5'd8, 2'b10);
    issue(2, 32'hDEAD_BEEF, 5'd8, 2'b10, ed, 1'b1, gc);
    set_req(0, 32'h0000_00A5, 5'd31, 2'b11);
    req_valid[0] = 1'b1;
    push_exp(0, model(32'h0000_00A5, 5'd31, 2'b11));
    @(negedge clk);
    ok = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (rsp_valid !== 4'b0100 || rsp_data !== ed || req_ready !== 4'd0) ok = 1'b0;
      @(negedge clk);
    end
    chk("hold_stable", {31'd0, ok}, 32'd1);
    reg_read(5'd1, rd);  chk("hold_status", rd, 32'h0000_0121);
    reg_read(5'd2, rd);  chk("hold_opcnt", rd, 32'd0);
    @(negedge clk);
    rsp_ready = 4'hF;
    wait_any_grant(gv, gc);
    chk("after_hold_grant", {28'd0, gv}, 32'd1);
    @(negedge clk);
    req_valid = 4'd0;
    drain();
    reg_read(5'd2, rd);  chk("opcnt_two", rd, 32'd2);

    // Reset in EXEC: op discarded, state and registers restored.
    reg_write(5'd0, 32'h0000_0301);
    issue(1, 32'h1357_9BDF, 5'd3, 2'b00, 32'd0, 1'b0, gc);
    reset = 1'b1;
    #1;
    chk("rst_exec_rspv", {28'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    acc = 4'd0;
    repeat (4) begin
      #1;
      acc = acc | rsp_valid;
      @(negedge clk);
    end
    chk("rst_no_rsp", {28'd0, acc}, 32'd0);
    chk("rst_rsp_data2", rsp_data, 32'd0);
    reg_read(5'd2, rd);  chk("rst_opcnt2", rd, 32'd0);
    reg_read(5'd0, rd);  chk("rst_ctrl2", rd, 32'h0000_0F01);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      set_req(i, 32'h0F0F_0F0F, 5'd12, 2'b01);
    end
    req_valid = 4'hF;
    push_exp(0, model(32'h0F0F_0F0F, 5'd12, 2'b01));
    wait_any_grant(gv, gc);
    chk("rst_first_grant", {28'd0, gv}, 32'd1);
    @(negedge clk);
    req_valid = 4'd0;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
